// File: rtl/fft_ctrl.sv
// Sequencing controller for an in-place radix-2 DIT FFT: issues butterfly reads,
// twiddle indices and the delayed write-backs, and inserts drain bubbles between stages.
module fft_ctrl #(
   parameter int LOG2N  = 8,
   parameter int RD_LAT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic [LOG2N-1:0] stage,
   output logic             rd_en,
   output logic [LOG2N-1:0] addr_a,
   output logic [LOG2N-1:0] addr_b,
   output logic [LOG2N-2:0] tw_addr,
   output logic             wr_en,
   output logic [LOG2N-1:0] wr_addr_a,
   output logic [LOG2N-1:0] wr_addr_b
);

   // state | meaning
   // IDLE  | waiting for start
   // RUN   | one butterfly read per cycle, j = 0..N/2-1
   // DRAIN | RD_LAT bubble cycles so the stage's writes land before the next stage reads
   // DONE  | one-cycle completion pulse
   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

   localparam int JW = LOG2N - 1;
   localparam int DW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   localparam logic [JW-1:0]    J_LAST     = {JW{1'b1}};
   localparam logic [LOG2N-1:0] S_LAST     = LOG2N'(LOG2N - 1);
   localparam logic [DW-1:0]    DRAIN_INIT = DW'(RD_LAT - 1);

   state_t           state, state_nxt;
   logic [JW-1:0]    j, j_nxt;
   logic [LOG2N-1:0] stage_r, stage_nxt;
   logic [DW-1:0]    drain_cnt, drain_nxt;

   logic             pipe_v [RD_LAT];
   logic [LOG2N-1:0] pipe_a [RD_LAT];
   logic [LOG2N-1:0] pipe_b [RD_LAT];

   // g*2^(s+1) + k is j with its bits above position s shifted up by one
   function automatic logic [LOG2N-1:0] calc_a(input logic [JW-1:0] jj, input logic [LOG2N-1:0] ss);
      logic [LOG2N-1:0] je;
      logic [LOG2N-1:0] mask;
      je     = {1'b0, jj};
      mask   = (LOG2N'(1) << ss) - LOG2N'(1);
      calc_a = ((je & ~mask) << 1) | (je & mask);
   endfunction

   function automatic logic [JW-1:0] calc_tw(input logic [JW-1:0] jj, input logic [LOG2N-1:0] ss);
      logic [JW-1:0]    mask;
      logic [LOG2N-1:0] sh;
      mask    = (JW'(1) << ss) - JW'(1);
      sh      = S_LAST - ss;
      calc_tw = (jj & mask) << sh;
   endfunction

   always_ff @(posedge clk) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      j_nxt     = j;
      stage_nxt = stage_r;
      drain_nxt = drain_cnt;
      case (state)
         ST_IDLE: begin
            if (start) begin
               state_nxt = ST_RUN;
               j_nxt     = '0;
               stage_nxt = '0;
            end
         end
         ST_RUN: begin
            if (j == J_LAST) begin
               state_nxt = ST_DRAIN;
               drain_nxt = DRAIN_INIT;
            end else begin
               j_nxt = j + JW'(1);
            end
         end
         ST_DRAIN: begin
            if (drain_cnt == '0) begin
               if (stage_r == S_LAST) begin
                  state_nxt = ST_DONE;
               end else begin
                  state_nxt = ST_RUN;
                  stage_nxt = stage_r + LOG2N'(1);
                  j_nxt     = '0;
               end
            end else begin
               drain_nxt = drain_cnt - DW'(1);
            end
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
            stage_nxt = '0;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Outputs are registered from next-state values so they line up with the state they describe
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         j         <= '0;
         stage_r   <= '0;
         drain_cnt <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         stage     <= '0;
         rd_en     <= 1'b0;
         addr_a    <= '0;
         addr_b    <= '0;
         tw_addr   <= '0;
      end else begin
         j         <= j_nxt;
         stage_r   <= stage_nxt;
         drain_cnt <= drain_nxt;
         busy      <= (state_nxt == ST_RUN) || (state_nxt == ST_DRAIN);
         done      <= (state_nxt == ST_DONE);
         stage     <= stage_nxt;
         rd_en     <= (state_nxt == ST_RUN);
         if (state_nxt == ST_RUN) begin
            addr_a  <= calc_a(j_nxt, stage_nxt);
            addr_b  <= calc_a(j_nxt, stage_nxt) | (LOG2N'(1) << stage_nxt);
            tw_addr <= calc_tw(j_nxt, stage_nxt);
         end else begin
            addr_a  <= '0;
            addr_b  <= '0;
            tw_addr <= '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < RD_LAT; i++) begin
            pipe_v[i] <= 1'b0;
            pipe_a[i] <= '0;
            pipe_b[i] <= '0;
         end
      end else begin
         pipe_v[0] <= rd_en;
         pipe_a[0] <= addr_a;
         pipe_b[0] <= addr_b;
         for (int i = 1; i < RD_LAT; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_a[i] <= pipe_a[i-1];
            pipe_b[i] <= pipe_b[i-1];
         end
      end
   end

   assign wr_en     = pipe_v[RD_LAT-1];
   assign wr_addr_a = pipe_a[RD_LAT-1];
   assign wr_addr_b = pipe_b[RD_LAT-1];

endmodule

// File: tb/tb_fft_ctrl.sv
// Directed bench for fft_ctrl: a per-cycle scoreboard of expected outputs is queued
// when a transform is started and checked entry by entry as the DUT runs.
module tb_fft_ctrl;

   logic clk;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // instance u3: LOG2N=3, RD_LAT=1
   logic       rst_n3, start3, busy3, done3, rd_en3, wr_en3;
   logic [2:0] stage3, addr_a3, addr_b3, wr_addr_a3, wr_addr_b3;
   logic [1:0] tw_addr3;
   // instance u4: LOG2N=4, RD_LAT=3
   logic       rst_n4, start4, busy4, done4, rd_en4, wr_en4;
   logic [3:0] stage4, addr_a4, addr_b4, wr_addr_a4, wr_addr_b4;
   logic [2:0] tw_addr4;

   fft_ctrl #(.LOG2N(3), .RD_LAT(1)) u3 (
      .clk(clk), .rst_n(rst_n3), .start(start3), .busy(busy3), .done(done3),
      .stage(stage3), .rd_en(rd_en3), .addr_a(addr_a3), .addr_b(addr_b3),
      .tw_addr(tw_addr3), .wr_en(wr_en3), .wr_addr_a(wr_addr_a3), .wr_addr_b(wr_addr_b3));

   fft_ctrl #(.LOG2N(4), .RD_LAT(3)) u4 (
      .clk(clk), .rst_n(rst_n4), .start(start4), .busy(busy4), .done(done4),
      .stage(stage4), .rd_en(rd_en4), .addr_a(addr_a4), .addr_b(addr_b4),
      .tw_addr(tw_addr4), .wr_en(wr_en4), .wr_addr_a(wr_addr_a4), .wr_addr_b(wr_addr_b4));

   typedef struct {
      logic        busy, done, rd, wr, drv;
      logic [31:0] stage, a, b, tw, wa, wb;
   } ent_t;

   ent_t q[$];
   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic sample(input int w, output ent_t o);
      o.drv = 1'b0;
      if (w == 3) begin
         o.busy = busy3; o.done = done3; o.rd = rd_en3; o.wr = wr_en3;
         o.stage = 32'(stage3); o.a = 32'(addr_a3); o.b = 32'(addr_b3);
         o.tw = 32'(tw_addr3); o.wa = 32'(wr_addr_a3); o.wb = 32'(wr_addr_b3);
      end else begin
         o.busy = busy4; o.done = done4; o.rd = rd_en4; o.wr = wr_en4;
         o.stage = 32'(stage4); o.a = 32'(addr_a4); o.b = 32'(addr_b4);
         o.tw = 32'(tw_addr4); o.wa = 32'(wr_addr_a4); o.wb = 32'(wr_addr_b4);
      end
   endtask

   task automatic set_start(input int w, input logic v);
      if (w == 3) start3 = v;
      else        start4 = v;
   endtask

   // butterfly addresses straight from the arithmetic definition
   task automatic bfly(input int l2n, input int s, input int j, output int a, output int b, output int tw);
      int half, k, g;
      half = 1 << s;
      k    = j % half;
      g    = j / half;
      a    = g * 2 * half + k;
      b    = a + half;
      tw   = (k << (l2n - 1 - s)) % (1 << (l2n - 1));
   endtask

   // queue expected outputs for cycles 1..done+1 (capped at 'last'); drv = start value driven next cycle
   task automatic push_seq(input int l2n, input int lat, input bit hold, input int s1, input int s2, input int last);
      int n2, p, d, a, b, tw;
      ent_t e;
      n2 = (1 << l2n) / 2;
      p  = n2 + lat;
      d  = 1 + l2n * p;
      for (int t = 1; t <= d + 1 && t <= last; t++) begin
         e.busy = (t <= l2n * p);
         e.done = (t == d);
         e.rd = 1'b0; e.wr = 1'b0;
         e.stage = 0; e.a = 0; e.b = 0; e.tw = 0; e.wa = 0; e.wb = 0;
         if (t <= l2n * p) begin
            e.stage = 32'((t - 1) / p);
            if ((t - 1) % p < n2) begin
               bfly(l2n, (t - 1) / p, (t - 1) % p, a, b, tw);
               e.rd = 1'b1; e.a = 32'(a); e.b = 32'(b); e.tw = 32'(tw);
            end
         end
         if (t - lat >= 1 && t - lat <= l2n * p && (t - lat - 1) % p < n2) begin
            bfly(l2n, (t - lat - 1) / p, (t - lat - 1) % p, a, b, tw);
            e.wr = 1'b1; e.wa = 32'(a); e.wb = 32'(b);
         end
         e.drv = hold || (t == s1) || (t == s2);
         q.push_back(e);
      end
   endtask

   task automatic run_q(input int w, input string name);
      ent_t e, o;
      int cyc = 0;
      while (q.size() > 0) begin
         @(negedge clk);
         cyc++;
         e = q.pop_front();
         sample(w, o);
         chk($sformatf("%s c%0d busy", name, cyc), 32'(o.busy), 32'(e.busy));
         chk($sformatf("%s c%0d done", name, cyc), 32'(o.done), 32'(e.done));
         chk($sformatf("%s c%0d rd_en", name, cyc), 32'(o.rd), 32'(e.rd));
         chk($sformatf("%s c%0d wr_en", name, cyc), 32'(o.wr), 32'(e.wr));
         if (e.busy) chk($sformatf("%s c%0d stage", name, cyc), o.stage, e.stage);
         if (e.rd) begin
            chk($sformatf("%s c%0d addr_a", name, cyc), o.a, e.a);
            chk($sformatf("%s c%0d addr_b", name, cyc), o.b, e.b);
            chk($sformatf("%s c%0d tw_addr", name, cyc), o.tw, e.tw);
         end
         if (e.wr) begin
            chk($sformatf("%s c%0d wr_addr_a", name, cyc), o.wa, e.wa);
            chk($sformatf("%s c%0d wr_addr_b", name, cyc), o.wb, e.wb);
         end
         set_start(w, e.drv);
      end
   endtask

   task automatic chk_zero(input int w, input string name);
      ent_t o;
      sample(w, o);
      chk({name, " busy"},  32'(o.busy), 0);
      chk({name, " done"},  32'(o.done), 0);
      chk({name, " rd_en"}, 32'(o.rd), 0);
      chk({name, " wr_en"}, 32'(o.wr), 0);
      chk({name, " stage"}, o.stage, 0);
      chk({name, " addr"},  o.a | o.b | o.tw, 0);
      chk({name, " wr_addr"}, o.wa | o.wb, 0);
   endtask

   initial begin
      rst_n3 = 1'b0; rst_n4 = 1'b0;
      start3 = 1'b0; start4 = 1'b0;
      repeat (3) @(negedge clk);
      chk_zero(3, "reset u3");
      chk_zero(4, "reset u4");
      rst_n3 = 1'b1; rst_n4 = 1'b1;
      @(negedge clk);

      // full LOG2N=3 transform from a single start pulse
      set_start(3, 1'b1);
      push_seq(3, 1, 1'b0, 0, 0, 1000);
      run_q(3, "u3 basic");

      // start pulses during RUN (c3) and DRAIN (c5) must be ignored
      @(negedge clk);
      set_start(3, 1'b1);
      push_seq(3, 1, 1'b0, 3, 5, 1000);
      run_q(3, "u3 ign");

      // start held high: second transform begins right after DONE
      @(negedge clk);
      set_start(3, 1'b1);
      push_seq(3, 1, 1'b1, 0, 0, 1000);
      push_seq(3, 1, 1'b0, 0, 0, 1000);
      run_q(3, "u3 hold");

      // RD_LAT=3 write delay, 3 bubbles per stage, done in cycle 45
      @(negedge clk);
      set_start(4, 1'b1);
      push_seq(4, 3, 1'b0, 0, 0, 1000);
      run_q(4, "u4 lat3");

      // reset during stage 1 RUN (cycle 7), then a clean restart
      @(negedge clk);
      set_start(3, 1'b1);
      push_seq(3, 1, 1'b0, 0, 0, 7);
      run_q(3, "u3 pre_rst");
      rst_n3 = 1'b0;
      @(negedge clk);
      chk_zero(3, "u3 mid_rst");
      rst_n3 = 1'b1;
      @(negedge clk);
      chk_zero(3, "u3 post_rst");
      set_start(3, 1'b1);
      push_seq(3, 1, 1'b0, 0, 0, 1000);
      run_q(3, "u3 restart");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fft_ctrl.md
# fft_ctrl

Sequencing controller for the in-place radix-2 decimation-in-time FFT datapath. It feeds the combinational butterfly unit. For every butterfly it issues a read of two operand addresses from the dual-port sample RAM and a twiddle ROM index. It then issues the matching write-back of the butterfly outputs to the same two addresses once the memory read latency has elapsed. It walks all stages of an N = 2^LOG2N point transform, inserts drain bubbles at stage boundaries to avoid read-after-write hazards, and signals completion. Input samples are already in bit-reversed order in RAM when `start` is issued; the loader handles that.

## Interface
- `LOG2N`, default 8: log2 of transform length; legal range 2..12.
- `RD_LAT`, default 1: sample RAM and twiddle ROM read latency in cycles; legal range 1..4.

- `clk`  in  1: single clock; all logic on rising edge.
- `rst_n`  in  1: reset; synchronous and active-low.
- `start`  in  1: begin a transform. Sampled only in IDLE.
- `busy`  out  1: high in RUN and DRAIN.
- `done`  out  1: one-cycle pulse when the final write-back has been issued.
- `stage`  out  LOG2N bits (holds 0..LOG2N-1): current stage index.
- `rd_en`  out  1: read strobe for both RAM ports and the twiddle ROM.
- `addr_a`  out  LOG2N: read address, top butterfly leg (routes to DINA).
- `addr_b`  out  LOG2N: read address, bottom butterfly leg (routes to DINB).
- `tw_addr`  out  LOG2N-1: twiddle ROM index.
- `wr_en`  out  1: write strobe for both RAM ports (DOUTA/DOUTB).
- `wr_addr_a`  out  LOG2N: write address for DOUTA.
- `wr_addr_b`  out  LOG2N: write address for DOUTB.

## Operation
- **FSM states:** IDLE, RUN, DRAIN, DONE.
  - IDLE: `start`=1 moves to RUN with stage=0 and j=0.
  - RUN: issues one butterfly per cycle, `rd_en`=1. j increments each cycle. At j = N/2-1 the FSM moves to DRAIN.
  - DRAIN: `rd_en`=0 for exactly RD_LAT cycles. Then, if stage = LOG2N-1, it moves to DONE; otherwise it increments stage, clears j, and returns to RUN.
  - DONE: `done`=1 for one cycle, then returns to IDLE.
- **Address generation** for stage s, butterfly j (j in 0..N/2-1):
  - half = 2^s, k = j mod half, g = j >> s.
  - addr_a = g·2^(s+1) + k.
  - addr_b = addr_a + half.
  - tw_addr = k << (LOG2N-1-s), truncated to LOG2N-1 bits.
- **Write pipeline:** a shift register of depth RD_LAT carries {`rd_en`, `addr_a`, `addr_b`}. Its output drives {`wr_en`, `wr_addr_a`, `wr_addr_b`}. Every read produces exactly one write, at the same addresses, RD_LAT cycles later.
- **Start handling:** `start` in RUN, DRAIN or DONE is ignored. `start` held high continuously restarts the transform immediately after DONE.
- **Hazard rule:**
  - The first read of stage s+1 occurs one cycle after the last write of stage s.
  - The RAM must present written data on the next cycle; write-first semantics are not required.
  - No read ever targets an address with a write still pending in the pipeline.
- **Reset** (`rst_n`=0 at a clock edge), including mid-transform:
  - State returns to IDLE; stage, j and the write pipeline clear.
  - All outputs read 0 on the following cycle; no stale `wr_en` is emitted.
  - RAM contents are left undefined; the transform must be restarted.

## Timing
- All outputs are registered. Reset value of every output is 0.
- Cycle 0 is the cycle in which `start` is sampled in IDLE.
  - The first `rd_en` is in cycle 1.
  - Stage s occupies cycles 1+s·(N/2+RD_LAT) through (s+1)·(N/2+RD_LAT).
  - `done` is high in cycle 1+LOG2N·(N/2+RD_LAT).
  - `busy` is high in cycles 1 through LOG2N·(N/2+RD_LAT).
- `wr_en` in cycle t equals `rd_en` in cycle t-RD_LAT. The last `wr_en` falls in the final DRAIN cycle.
- Throughput: N/2 butterflies per stage at one per cycle. Bubble overhead is RD_LAT cycles per stage.
- Back-to-back transforms: the next cycle 0 is at earliest the cycle after DONE.

## Test plan
- **Reset values:** LOG2N=3, RD_LAT=1; hold `rst_n`=0 for 3 cycles -> all outputs 0; `busy`=0.
- **Stage 0 addresses:** `start` pulse -> stage 0 reads (0,1),(2,3),(4,5),(6,7), all with `tw_addr`=0. Then exactly one cycle with `rd_en`=0 and `wr_en`=1 to (6,7).
- **Stages 1 and 2 addresses:**
  - Stage 1 -> (0,2)/0, (1,3)/2, (4,6)/0, (5,7)/2.
  - Stage 2 -> (0,4)/0, (1,5)/1, (2,6)/2, (3,7)/3.
  - `done` is high in cycle 16 only; `busy` is high in cycles 1..15.
- **Write latency:** RD_LAT=3, LOG2N=4 -> every `wr_en` is exactly 3 cycles after its `rd_en` with identical addresses. There are 3 bubble cycles per stage, and `done` is in cycle 45.
- **Reset mid-operation:**
  - Assert `rst_n`=0 in stage 1 mid-RUN -> the next cycle has `wr_en`=0, `busy`=0, `stage`=0.
  - A subsequent `start` reproduces the full stage-0 sequence.
- **Start handling:** a `start` pulse during RUN has no effect on sequence or timing. `start` held high -> a new transform begins at cycle 0 immediately after the DONE cycle.
